// File: rtl/centroid_tracker_pkg.sv
// Shared pixel-pipeline definitions: tracker state encoding and default widths.
package centroid_tracker_pkg;

  localparam int DEF_X_W   = 11;
  localparam int DEF_Y_W   = 10;
  localparam int DEF_DIV_W = 32;

  typedef enum logic {
    ACCUM  = 1'b0,
    DIVIDE = 1'b1
  } state_t;

endpackage

// File: rtl/centroid_tracker_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; only the low RES_W
// quotient bits are published, and only when the whole division is finished.
module centroid_tracker_divider
  import centroid_tracker_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int RES_W = DEF_X_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] quot_r, rem_r, div_r;
  logic [DIV_W-1:0] quot_nx, rem_nx;
  logic [DIV_W:0]   rem_sh, diff;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    rem_sh = {rem_r, quot_r[DIV_W-1]};
    diff   = rem_sh - {1'b0, div_r};
    if (diff[DIV_W]) begin
      rem_nx  = rem_sh[DIV_W-1:0];
      quot_nx = {quot_r[DIV_W-2:0], 1'b0};
    end else begin
      rem_nx  = diff[DIV_W-1:0];
      quot_nx = {quot_r[DIV_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        cnt  <= CNT_W'(DIV_W);
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= quot_nx[RES_W-1:0];
        end
      end
    end
  end

  // Working registers are pure datapath; the handshake above gates their use.
  always_ff @(posedge clk_in) begin
    if (start && !busy) begin
      quot_r <= dividend;
      rem_r  <= '0;
      div_r  <= divisor;
    end else if (busy) begin
      quot_r <= quot_nx;
      rem_r  <= rem_nx;
    end
  end

endmodule

// File: rtl/centroid_tracker.sv
// Accumulates masked pixel coordinates over a frame and divides by the pixel
// count at end of frame to produce the blob centroid.
module centroid_tracker
  import centroid_tracker_pkg::*;
#(
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic           valid_in,
  input  logic           tabulate_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           valid_out
);

  state_t           state;
  logic [DIV_W-1:0] sum_x, sum_y, count;
  logic [DIV_W-1:0] sum_x_nx, sum_y_nx, count_nx;
  logic [DIV_W-1:0] snap_x_p1, snap_y_p1, snap_cnt_p1;
  logic             start_p1;
  logic             busy_x, busy_y, done_x, done_y;

  // A pixel coincident with tabulate_in still belongs to the closing frame.
  always_comb begin
    sum_x_nx = sum_x + (valid_in ? DIV_W'(x_in) : '0);
    sum_y_nx = sum_y + (valid_in ? DIV_W'(y_in) : '0);
    count_nx = count + (valid_in ? DIV_W'(1) : '0);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ACCUM;
      sum_x    <= '0;
      sum_y    <= '0;
      count    <= '0;
      start_p1 <= 1'b0;
    end else begin
      start_p1 <= 1'b0;
      if (tabulate_in) begin
        sum_x <= '0;
        sum_y <= '0;
        count <= '0;
        if (state == ACCUM && count_nx != '0) begin
          state    <= DIVIDE;
          start_p1 <= 1'b1;
        end
      end else begin
        sum_x <= sum_x_nx;
        sum_y <= sum_y_nx;
        count <= count_nx;
      end
      if (state == DIVIDE && !start_p1 && !busy_x && !busy_y)
        state <= ACCUM;
    end
  end

  // Stage p1: frame totals held for the dividers to load.
  always_ff @(posedge clk_in) begin
    if (tabulate_in && state == ACCUM && count_nx != '0) begin
      snap_x_p1   <= sum_x_nx;
      snap_y_p1   <= sum_y_nx;
      snap_cnt_p1 <= count_nx;
    end
  end

  // Both dividers share start and latency, so they finish together.
  centroid_tracker_divider #(.DIV_W(DIV_W), .RES_W(X_W)) u_div_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (start_p1),
    .dividend (snap_x_p1),
    .divisor  (snap_cnt_p1),
    .busy     (busy_x),
    .done     (done_x),
    .quotient (x_out)
  );

  centroid_tracker_divider #(.DIV_W(DIV_W), .RES_W(Y_W)) u_div_y (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (start_p1),
    .dividend (snap_y_p1),
    .divisor  (snap_cnt_p1),
    .busy     (busy_y),
    .done     (done_y),
    .quotient (y_out)
  );

  assign valid_out = done_x & done_y;

endmodule

// File: tb/tb_centroid_tracker.sv
// Self-checking bench for centroid_tracker: directed frame table, multi-cycle
// corner sequences, and random traffic against a frame-level reference model.
module tb_centroid_tracker;

  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int DIV_W = 32;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic [X_W-1:0] x_in;
  logic [Y_W-1:0] y_in;
  logic           valid_in;
  logic           tabulate_in;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic           valid_out;

  always #5 clk_in = ~clk_in;

  centroid_tracker #(.X_W(X_W), .Y_W(Y_W), .DIV_W(DIV_W)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .x_in        (x_in),
    .y_in        (y_in),
    .valid_in    (valid_in),
    .tabulate_in (tabulate_in),
    .x_out       (x_out),
    .y_out       (y_out),
    .valid_out   (valid_out)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: running frame totals plus a scheduled result.
  logic [DIV_W-1:0] m_sx, m_sy, m_cnt;
  longint           kcyc = 0;
  longint           busy_until = -1;
  longint           emit_at = -1;
  logic [X_W-1:0]   m_xo, res_x;
  logic [Y_W-1:0]   m_yo, res_y;
  logic             m_vo;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, kcyc);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [X_W-1:0] xv,
                            input logic [Y_W-1:0] yv, input bit t);
    logic [DIV_W-1:0] nsx, nsy, nc;
    if (r) begin
      m_sx = '0; m_sy = '0; m_cnt = '0;
      busy_until = -1; emit_at = -1;
      m_xo = '0; m_yo = '0; m_vo = 1'b0;
    end else begin
      nsx = m_sx + (v ? DIV_W'(xv) : '0);
      nsy = m_sy + (v ? DIV_W'(yv) : '0);
      nc  = m_cnt + (v ? DIV_W'(1) : '0);
      m_vo = (emit_at == kcyc + 1);
      if (m_vo) begin
        m_xo = res_x;
        m_yo = res_y;
      end
      if (t) begin
        if (kcyc > busy_until && nc != 0) begin
          res_x = X_W'(nsx / nc);
          res_y = Y_W'(nsy / nc);
          emit_at = kcyc + DIV_W + 2;
          busy_until = emit_at;
        end
        m_sx = '0; m_sy = '0; m_cnt = '0;
      end else begin
        m_sx = nsx; m_sy = nsy; m_cnt = nc;
      end
    end
    kcyc++;
  endtask

  task automatic cycle(input bit r, input bit v, input int x, input int y, input bit t);
    rst_in = r; valid_in = v; x_in = X_W'(x); y_in = Y_W'(y); tabulate_in = t;
    @(posedge clk_in); #1;
    model_step(r, v, X_W'(x), Y_W'(y), t);
    check("valid_out", 64'(valid_out), 64'(m_vo));
    check("x_out", 64'(x_out), 64'(m_xo));
    check("y_out", 64'(y_out), 64'(m_yo));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic watch(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      idle(1);
      if (valid_out === 1'b1) pulses++;
    end
  endtask

  typedef struct {
    int n;
    int x0, y0, x1, y1, x2, y2;
    int ex, ey;
    bit ev;
  } vec_t;

  vec_t vec[6];
  int   pulses, hit;

  initial begin
    vec[0] = '{1, 100, 50, 0, 0, 0, 0, 100, 50, 1'b1};
    vec[1] = '{3, 0, 0, 3, 0, 10, 21, 4, 7, 1'b1};
    vec[2] = '{0, 0, 0, 0, 0, 0, 0, 4, 7, 1'b0};
    vec[3] = '{2, 1, 1, 2, 2, 0, 0, 1, 1, 1'b1};
    vec[4] = '{3, 2047, 1023, 2047, 1023, 2046, 1022, 2046, 1022, 1'b1};
    vec[5] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1};

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 5, 5, 1);
    check("reset_x", 64'(x_out), 64'd0);
    check("reset_y", 64'(y_out), 64'd0);
    check("reset_valid", 64'(valid_out), 64'd0);

    // Directed frames: result exactly DIV_W+2 cycles after tabulate
    for (int i = 0; i < 6; i++) begin
      if (vec[i].n > 0) cycle(0, 1, vec[i].x0, vec[i].y0, 0);
      if (vec[i].n > 1) cycle(0, 1, vec[i].x1, vec[i].y1, 0);
      if (vec[i].n > 2) cycle(0, 1, vec[i].x2, vec[i].y2, 0);
      cycle(0, 0, 0, 0, 1);
      pulses = 0; hit = 0;
      for (int j = 1; j <= DIV_W + 1; j++) begin
        idle(1);
        if (valid_out === 1'b1) begin
          pulses++;
          if (j == DIV_W + 1) hit = 1;
        end
      end
      check($sformatf("vec%0d_pulses", i), 64'(pulses), 64'(vec[i].ev));
      check($sformatf("vec%0d_on_time", i), 64'(hit), 64'(vec[i].ev));
      check($sformatf("vec%0d_x", i), 64'(x_out), 64'(vec[i].ex));
      check($sformatf("vec%0d_y", i), 64'(y_out), 64'(vec[i].ey));
      idle(1);
    end

    // Second tabulate 5 cycles after the first is dropped
    cycle(0, 1, 20, 30, 0);
    cycle(0, 1, 40, 10, 0);
    cycle(0, 0, 0, 0, 1);
    idle(1);
    cycle(0, 1, 500, 500, 0);
    idle(2);
    cycle(0, 0, 0, 0, 1);
    watch(2 * DIV_W, pulses);
    check("drop_pulses", 64'(pulses), 64'd1);
    check("drop_x", 64'(x_out), 64'd30);
    check("drop_y", 64'(y_out), 64'd20);
    cycle(0, 1, 9, 3, 0);
    cycle(0, 0, 0, 0, 1);
    watch(DIV_W + 3, pulses);
    check("clean_pulses", 64'(pulses), 64'd1);
    check("clean_x", 64'(x_out), 64'd9);
    check("clean_y", 64'(y_out), 64'd3);

    // Reset while dividing aborts the result
    cycle(0, 1, 100, 100, 0);
    cycle(0, 0, 0, 0, 1);
    idle(10);
    cycle(1, 1, 555, 555, 0);
    cycle(1, 0, 0, 0, 0);
    check("abort_x", 64'(x_out), 64'd0);
    check("abort_y", 64'(y_out), 64'd0);
    watch(DIV_W + 5, pulses);
    check("abort_pulses", 64'(pulses), 64'd0);
    cycle(0, 1, 7, 9, 0);
    cycle(0, 0, 0, 0, 1);
    watch(DIV_W + 3, pulses);
    check("after_rst_pulses", 64'(pulses), 64'd1);
    check("after_rst_x", 64'(x_out), 64'd7);
    check("after_rst_y", 64'(y_out), 64'd9);

    // Wide frame: all 1280 columns over rows symmetric about the 720-line centre
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 1280; c++)
        cycle(0, 1, c, (r < 16) ? r : 688 + r, 0);
    end
    cycle(0, 0, 0, 0, 1);
    watch(DIV_W + 3, pulses);
    check("frame_pulses", 64'(pulses), 64'd1);
    check("frame_x", 64'(x_out), 64'd639);
    check("frame_y", 64'(y_out), 64'd359);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 499) == 0),
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 2047)),
            int'($urandom_range(0, 1023)),
            ($urandom_range(0, 39) == 0));
    end
    idle(DIV_W + 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/centroid_tracker.md
CENTROID_TRACKER -- requirements
Module: centroid_tracker

Interface
REQ-001 SHALL have parameter X_W, default 11, pixel x-coordinate width.
REQ-002 SHALL have parameter Y_W, default 10, pixel y-coordinate width.
REQ-003 SHALL have parameter DIV_W, default 32, accumulator and divider width.
REQ-004 SHALL have port clk_in  input  1  single system/pixel clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-006 SHALL have port x_in  input  X_W  column of current pixel.
REQ-007 SHALL have port y_in  input  Y_W  row of current pixel.
REQ-008 SHALL have port valid_in  input  1  current pixel passes threshold (mask bit set).
REQ-009 SHALL have port tabulate_in  input  1  one-cycle end-of-frame strobe.
REQ-010 SHALL have port x_out  output  X_W  centroid column, feeds crosshair/sprite position for the display mux.
REQ-011 SHALL have port y_out  output  Y_W  centroid row.
REQ-012 SHALL have port valid_out  output  1  one-cycle pulse when x_out/y_out update.

Function
REQ-013 SHALL keep DIV_W-bit sum_x, sum_y and count; on valid_in: sum_x += x_in, sum_y += y_in, count += 1, all unsigned, no saturation.
REQ-014 SHALL, on tabulate_in, count a coincident valid_in pixel toward the closing frame, snapshot the three totals, and clear accumulators to 0 in the same cycle.
REQ-015 SHALL resume accumulating the new frame the cycle after tabulate_in, including while dividing.
REQ-016 SHALL implement states ACCUM (idle, no division) and DIVIDE (division in flight).
REQ-017 SHALL, on tabulate_in in ACCUM with snapshot count > 0, enter DIVIDE and start both divisions (sum_x/count, sum_y/count) the next cycle.
REQ-018 SHALL, on tabulate_in in ACCUM with snapshot count == 0, stay in ACCUM, assert no valid_out, and hold x_out/y_out.
REQ-019 SHALL, on tabulate_in during DIVIDE, drop that frame: accumulators cleared, division in flight unaffected, no extra result.
REQ-020 SHALL compute quotients by restoring division, one quotient bit per cycle, truncating toward zero.
REQ-021 SHALL assert valid_out for exactly one cycle exactly DIV_W+2 cycles after the accepting tabulate_in cycle, then return to ACCUM.
REQ-022 SHALL load x_out/y_out with the low X_W/Y_W quotient bits in the same cycle valid_out asserts, and hold them until the next result.
REQ-023 SHALL have both dividers complete in the same cycle; a division result SHALL never be partially visible.

Reset
REQ-024 SHALL, while rst_in is high, force state ACCUM, accumulators 0, x_out 0, y_out 0, valid_out 0, dividers idle.
REQ-025 SHALL abort any in-flight division on rst_in with no valid_out afterward; the first pixel after reset release starts a fresh frame.

Structure
REQ-026 SHALL place the state enum and default width constants in the shared pixel package.
REQ-027 SHALL use one sub-module, divider (DIV_W-bit restoring, start/busy/done handshake, active-high synchronous rst_in), instantiated twice.

Verification
REQ-028 SHALL test single pixel (100,50), tabulate -> valid_out after DIV_W+2 cycles, x_out=100, y_out=50.
REQ-029 SHALL test pixels (0,0),(3,0),(10,21) -> x_out=4, y_out=7 (truncation).
REQ-030 SHALL test an empty frame after a valid result -> no valid_out, outputs unchanged.
REQ-031 SHALL test a full 1280x720 frame, all valid -> x_out=639, y_out=359, no overflow.
REQ-032 SHALL test a second tabulate 5 cycles after the first -> exactly one valid_out with frame-1 values; next frame's accumulation starts clean.
REQ-033 SHALL test rst_in mid-DIVIDE -> no valid_out, outputs 0; a following frame with pixel (7,9) yields (7,9).
